decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV32I decode stage directly downstream of fetch.
- Consumes fetch's registered instruction, PC and PC+4 over a valid/ready handshake.
- Emits a registered, fully decoded micro-op to rename/dispatch.
- Contains a 2-entry elastic buffer (output register plus skid register), so fetch sees a registered ready with no combinational path from ready_out to ready_in.

Parameters:
- XLEN, 32, datapath width for PC and immediates; only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- flush  in  1  squash all held entries; active-high
- instr_in  in  32  instruction word from fetch
- pc_in  in  32  instruction PC
- pc_4_in  in  32  PC+4
- valid_in  in  1  fetch output valid
- ready_in  out  1  decode can accept this cycle
- ready_out  in  1  downstream can accept
- valid_out  out  1  decoded uop valid
- uop_out  out  decode_pkg::uop_t  decoded uop, packed struct:
  - pc, pc_4
  - opcode[6:0], funct3, funct7
  - rd, rs1, rs2
  - imm[31:0]
  - fu_type, uses_rs1, uses_rs2, uses_rd
  - is_load, is_store, is_branch, is_jump
  - illegal

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (reset==0 at posedge):
  - valid_out=0, skid_valid=0, ready_in=1.
  - uop_out, including skid contents, cleared to all-zero.
- Decode logic:
  - Combinational on instr_in, pc_in and pc_4_in.
  - The decoded uop is what gets stored in both registers; the raw instruction word is not stored.
- Accept condition: valid_in && ready_in.
- ready_in is the registered value of !skid_valid.
- Latency and throughput:
  - 1 cycle from accept to valid_out when the output register is free.
  - Throughput 1 uop/cycle while ready_out=1.
- Output register loads when !valid_out || ready_out:
  - Source is the skid entry if skid_valid, else the accepted input.
  - If neither is available, valid_out goes to 0.
- Skid register:
  - Loads the accepted input when the output register holds and does not drain (valid_out && !ready_out).
  - When the skid entry moves to the output, skid_valid clears.
  - An input accepted in that same cycle goes to the skid (ready_in was 1 only if the skid was empty beforehand).
- Order is strictly preserved.
- No entry is dropped or duplicated under any backpressure pattern.
- Stability: uop_out stays stable while valid_out && !ready_out.
- Flush:
  - Next cycle: valid_out=0, skid_valid=0, ready_in=1.
  - The input presented in the flush cycle is discarded.
  - Flush has priority over accept.
  - Reset has priority over flush.
- Immediates are sign-extended to 32 bits:
  - I-type: OP-IMM, LOAD, JALR.
  - S-type: STORE.
  - B-type: BRANCH, bit0=0.
  - U-type: LUI, AUIPC, low 12 bits zero.
  - J-type: JAL, bit0=0.
  - R-type, SYSTEM: imm=0.
- Register-use flags:
  - uses_rd=0 when rd==0, and for STORE and BRANCH.
  - uses_rs1=0 for LUI, AUIPC and JAL.
  - uses_rs2=1 only for OP, STORE and BRANCH.
- fu_type values:
  - ALU: OP, OP-IMM, LUI, AUIPC.
  - BRU: BRANCH, JAL, JALR.
  - LSU: LOAD, STORE.
  - MDU: M-extension, when enabled.
  - NONE: otherwise.
- Illegal instructions:
  - illegal=1 if instr[1:0]!=2'b11, the opcode is unknown, or funct3 is invalid for LOAD, STORE or BRANCH.
  - Illegal uops still flow through the pipeline with illegal=1, fu_type=NONE and all uses_* flags = 0.
- FENCE and SYSTEM decode as fu_type NONE, not illegal.

Optional Feature:
- Macro: DECODE_RV32M_EN.
- Defined: OP with funct7=7'b0000001 decodes as fu_type=MDU, uses_rs1/rs2/rd set normally.
- Undefined: the same encoding sets illegal=1 and fu_type=NONE.

Decomposition:
- decode_pkg holds:
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM).
  - fu_type_e enum: NONE, ALU, BRU, LSU, MDU.
  - uop_t packed struct.
- One sub-module, rv32_decoder: purely combinational instruction → uop_t.
- decode_stage holds the elastic buffer and handshake.

Test Plan:
- Reset and single accept: reset low 2 cycles, then release.
  - Required after release: ready_in=1, valid_out=0.
  - Stimulus: addi x1,x2,-5 (0xFFB10093), pc_in=0x100.
  - Required next cycle: valid_out=1, rd=1, rs1=2, imm=0xFFFFFFFB, fu_type=ALU, pc=0x100, pc_4=0x104.
- Immediate formats:
  - lw x5,8(x6) (0x00832283) → imm=8, is_load=1, fu_type=LSU.
  - lui x10,0x12345 (0x12345537) → imm=0x12345000, uses_rs1=0.
  - beq x1,x2,-4 (0xFE208EE3) → imm=0xFFFFFFFC, uses_rd=0, is_branch=1.
- Backpressure: stream 5 consecutive instructions, ready_out=0 for 3 cycles.
  - ready_in drops after 2 accepts; uop_out is held stable.
  - On ready_out=1, all 5 emerge in order; no loss or duplicates.
- Flush mid-stall: both entries full, assert flush.
  - Required next cycle: valid_out=0, ready_in=1.
  - Held uops never appear at the output.
- M-extension: mul x3,x1,x2 (0x022081B3).
  - With DECODE_RV32M_EN: fu_type=MDU.
  - Without it: illegal=1.
  - Also 0x00000000 → illegal=1.
- Reset mid-operation: with both entries full, pull reset low for 1 cycle.
  - Required: valid_out=0, uop_out=0, ready_in=1.
  - Normal acceptance resumes the next cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage: opcodes, FU classes, uop bundle.
// Exports OPC_* localparams, fu_type_e, uop_t and funct3 legality helpers.
package decode_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [2:0] {
    FU_NONE = 3'd0,
    FU_ALU  = 3'd1,
    FU_BRU  = 3'd2,
    FU_LSU  = 3'd3,
    FU_MDU  = 3'd4
  } fu_type_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    fu_type_e    fu_type;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        uses_rd;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
  } uop_t;

  // LB/LH/LW/LBU/LHU only
  function automatic logic load_f3_ok(
    input logic [2:0] f3
  );
    return (f3 != 3'b011) &&
           (f3 != 3'b110) &&
           (f3 != 3'b111);
  endfunction

  // SB/SH/SW only
  function automatic logic store_f3_ok(
    input logic [2:0] f3
  );
    return (f3 == 3'b000) ||
           (f3 == 3'b001) ||
           (f3 == 3'b010);
  endfunction

  // 010 and 011 are unassigned
  function automatic logic branch_f3_ok(
    input logic [2:0] f3
  );
    return (f3 != 3'b010) &&
           (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/rv32_decoder.sv
// Combinational RV32I instruction -> uop_t decoder.
// Ports: instr, pc, pc_4 in; uop out. DECODE_RV32M_EN enables MDU ops.
module rv32_decoder
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc_4,
  output uop_t        uop
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        ill;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign imm_i = {{20{instr[31]}},
                  instr[31:20]};
  assign imm_s = {{20{instr[31]}},
                  instr[31:25],
                  instr[11:7]};
  assign imm_b = {{19{instr[31]}},
                  instr[31],
                  instr[7],
                  instr[30:25],
                  instr[11:8],
                  1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}},
                  instr[31],
                  instr[19:12],
                  instr[20],
                  instr[30:21],
                  1'b0};

  always_comb begin
    uop          = '0;
    ill          = 1'b0;
    uop.pc       = pc;
    uop.pc_4     = pc_4;
    uop.opcode   = opc;
    uop.funct3   = f3;
    uop.funct7   = f7;
    uop.rd       = instr[11:7];
    uop.rs1      = instr[19:15];
    uop.rs2      = instr[24:20];
    uop.fu_type  = FU_NONE;
    uop.uses_rs1 = 1'b1;
    uop.uses_rs2 = 1'b0;
    uop.uses_rd  = 1'b1;

    unique case (1'b1)
      (opc == OPC_LUI),
      (opc == OPC_AUIPC): begin
        uop.imm      = imm_u;
        uop.fu_type  = FU_ALU;
        uop.uses_rs1 = 1'b0;
      end
      (opc == OPC_JAL): begin
        uop.imm      = imm_j;
        uop.fu_type  = FU_BRU;
        uop.uses_rs1 = 1'b0;
        uop.is_jump  = 1'b1;
      end
      (opc == OPC_JALR): begin
        uop.imm     = imm_i;
        uop.fu_type = FU_BRU;
        uop.is_jump = 1'b1;
      end
      (opc == OPC_BRANCH): begin
        uop.imm       = imm_b;
        uop.fu_type   = FU_BRU;
        uop.uses_rs2  = 1'b1;
        uop.uses_rd   = 1'b0;
        uop.is_branch = 1'b1;
        ill           = !branch_f3_ok(f3);
      end
      (opc == OPC_LOAD): begin
        uop.imm     = imm_i;
        uop.fu_type = FU_LSU;
        uop.is_load = 1'b1;
        ill         = !load_f3_ok(f3);
      end
      (opc == OPC_STORE): begin
        uop.imm      = imm_s;
        uop.fu_type  = FU_LSU;
        uop.uses_rs2 = 1'b1;
        uop.uses_rd  = 1'b0;
        uop.is_store = 1'b1;
        ill          = !store_f3_ok(f3);
      end
      (opc == OPC_OPIMM): begin
        uop.imm     = imm_i;
        uop.fu_type = FU_ALU;
      end
      (opc == OPC_OP): begin
        uop.uses_rs2 = 1'b1;
        if (f7 == F7_MULDIV) begin
`ifdef DECODE_RV32M_EN
          uop.fu_type = FU_MDU;
`else
          ill = 1'b1;
`endif
        end else begin
          uop.fu_type = FU_ALU;
        end
      end
      (opc == OPC_FENCE): begin
        uop.imm = imm_i;
      end
      (opc == OPC_SYSTEM): begin
        uop.imm = '0;
      end
      default: begin
        ill = 1'b1;
      end
    endcase

    if (instr[1:0] != 2'b11) begin
      ill = 1'b1;
    end

    if (uop.rd == 5'd0) begin
      uop.uses_rd = 1'b0;
    end

    // illegal uops travel on but must not
    // claim any resource downstream
    if (ill) begin
      uop.fu_type   = FU_NONE;
      uop.uses_rs1  = 1'b0;
      uop.uses_rs2  = 1'b0;
      uop.uses_rd   = 1'b0;
      uop.is_load   = 1'b0;
      uop.is_store  = 1'b0;
      uop.is_branch = 1'b0;
      uop.is_jump   = 1'b0;
    end
    uop.illegal = ill;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: rv32_decoder plus 2-entry elastic buffer (out + skid).
// Ports: clk, reset(n), flush, fetch in/valid/ready, uop out/valid/ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_4_in,
  input  logic            valid_in,
  output logic            ready_in,
  input  logic            ready_out,
  output logic            valid_out,
  output uop_t            uop_out
);

  uop_t dec_uop;
  uop_t skid_q;
  logic skid_valid;
  logic accept;
  logic out_load;
  logic skid_valid_d;

  rv32_decoder u_dec (
    .instr (instr_in),
    .pc    (pc_in),
    .pc_4  (pc_4_in),
    .uop   (dec_uop)
  );

  assign accept   = valid_in && ready_in;
  assign out_load = !valid_out || ready_out;

  // ready_in is the registered copy of
  // this, so fetch never sees ready_out
  always_comb begin
    skid_valid_d = skid_valid;
    if (out_load) begin
      skid_valid_d = skid_valid && accept;
    end else if (accept) begin
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_out  <= 1'b0;
      uop_out    <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
      ready_in   <= 1'b1;
    end else if (flush) begin
      valid_out  <= 1'b0;
      skid_valid <= 1'b0;
      ready_in   <= 1'b1;
    end else begin
      if (out_load) begin
        if (skid_valid) begin
          uop_out   <= skid_q;
          valid_out <= 1'b1;
        end else if (accept) begin
          uop_out   <= dec_uop;
          valid_out <= 1'b1;
        end else begin
          valid_out <= 1'b0;
        end
      end
      // skid takes the input whenever the
      // output register is not taking it
      if (accept && (skid_valid || !out_load)) begin
        skid_q <= dec_uop;
      end
      skid_valid <= skid_valid_d;
      ready_in   <= !skid_valid_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
// Covers reset, immediates, backpressure, flush, M-ext, mid-run reset.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic [31:0] pc_4_in;
  logic        valid_in;
  logic        ready_in;
  logic        ready_out;
  logic        valid_out;
  uop_t        uop_out;

  int checks = 0;
  int errors = 0;

  decode_stage #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .instr_in  (instr_in),
    .pc_in     (pc_in),
    .pc_4_in   (pc_4_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .uop_out   (uop_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [31:0] ins,
    input logic [31:0] pc
  );
    instr_in = ins;
    pc_in    = pc;
    pc_4_in  = pc + 32'd4;
    valid_in = 1'b1;
  endtask

  function automatic logic [31:0] addi_enc(
    input int i
  );
    return (32'(i) << 20) |
           (32'(i) << 7) | 32'h13;
  endfunction

  task automatic test_reset();
    reset     = 1'b0;
    flush     = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    instr_in  = '0;
    pc_in     = '0;
    pc_4_in   = '0;
    step();
    step();
    checks++;
    if (uop_out !== '0) begin
      errors++;
      $display("FAIL rst_uop got=%h exp=0",
               uop_out);
    end
    reset = 1'b1;
    step();
    checks++;
    if (ready_in !== 1'b1 ||
        valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_hs got=%b%b exp=10",
               ready_in, valid_out);
    end
    drive(32'hFFB10093, 32'h100);
    step();
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 ||
        uop_out.rd !== 5'd1 ||
        uop_out.rs1 !== 5'd2) begin
      errors++;
      $display("FAIL addi_regs got v=%b rd=%0d rs1=%0d exp v=1 rd=1 rs1=2",
               valid_out, uop_out.rd,
               uop_out.rs1);
    end
    checks++;
    if (uop_out.imm !== 32'hFFFFFFFB ||
        uop_out.fu_type !== FU_ALU) begin
      errors++;
      $display("FAIL addi_imm got=%h fu=%0d exp=fffffffb fu=1",
               uop_out.imm,
               uop_out.fu_type);
    end
    checks++;
    if (uop_out.pc !== 32'h100 ||
        uop_out.pc_4 !== 32'h104) begin
      errors++;
      $display("FAIL addi_pc got=%h/%h exp=100/104",
               uop_out.pc, uop_out.pc_4);
    end
    step();
  endtask

  task automatic test_imm_formats();
    ready_out = 1'b1;
    drive(32'h00832283, 32'h400);
    step();
    checks++;
    if (uop_out.imm !== 32'd8 ||
        uop_out.is_load !== 1'b1 ||
        uop_out.fu_type !== FU_LSU) begin
      errors++;
      $display("FAIL lw got imm=%h ld=%b fu=%0d exp imm=8 ld=1 fu=3",
               uop_out.imm, uop_out.is_load,
               uop_out.fu_type);
    end
    drive(32'h12345537, 32'h404);
    step();
    checks++;
    if (uop_out.imm !== 32'h12345000 ||
        uop_out.uses_rs1 !== 1'b0) begin
      errors++;
      $display("FAIL lui got imm=%h rs1u=%b exp imm=12345000 rs1u=0",
               uop_out.imm, uop_out.uses_rs1);
    end
    drive(32'hFE208EE3, 32'h408);
    step();
    checks++;
    if (uop_out.imm !== 32'hFFFFFFFC ||
        uop_out.uses_rd !== 1'b0 ||
        uop_out.is_branch !== 1'b1) begin
      errors++;
      $display("FAIL beq got imm=%h rdu=%b br=%b exp imm=fffffffc rdu=0 br=1",
               uop_out.imm, uop_out.uses_rd,
               uop_out.is_branch);
    end
    drive(32'h00532423, 32'h40C);
    step();
    checks++;
    if (uop_out.imm !== 32'd8 ||
        uop_out.is_store !== 1'b1 ||
        uop_out.uses_rd !== 1'b0 ||
        uop_out.uses_rs2 !== 1'b1) begin
      errors++;
      $display("FAIL sw got imm=%h st=%b rdu=%b rs2u=%b exp 8,1,0,1",
               uop_out.imm, uop_out.is_store,
               uop_out.uses_rd,
               uop_out.uses_rs2);
    end
    drive(32'h0080006F, 32'h410);
    step();
    valid_in = 1'b0;
    checks++;
    if (uop_out.imm !== 32'd8 ||
        uop_out.fu_type !== FU_BRU ||
        uop_out.is_jump !== 1'b1 ||
        uop_out.uses_rd !== 1'b0) begin
      errors++;
      $display("FAIL jal got imm=%h fu=%0d j=%b rdu=%b exp 8,2,1,0",
               uop_out.imm, uop_out.fu_type,
               uop_out.is_jump,
               uop_out.uses_rd);
    end
    step();
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    int dups = 0;
    logic [31:0] exp_pc;
    ready_out = 1'b0;
    drive(addi_enc(0), 32'h200);
    step();
    sent = 1;
    drive(addi_enc(1), 32'h204);
    step();
    sent = 2;
    drive(addi_enc(2), 32'h208);
    checks++;
    if (ready_in !== 1'b0 ||
        valid_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_full got rdy=%b v=%b exp rdy=0 v=1",
               ready_in, valid_out);
    end
    step();
    checks++;
    if (uop_out.pc !== 32'h200 ||
        ready_in !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got pc=%h rdy=%b exp pc=200 rdy=0",
               uop_out.pc, ready_in);
    end
    ready_out = 1'b1;
    for (int c = 0; c < 40 && got < 5; c++) begin
      logic acc;
      if (sent < 5) begin
        drive(addi_enc(sent),
              32'h200 + 32'(sent) * 4);
      end else begin
        valid_in = 1'b0;
      end
      acc = valid_in && ready_in;
      if (valid_out) begin
        exp_pc = 32'h200 + 32'(got) * 4;
        if (uop_out.pc !== exp_pc ||
            uop_out.rd !== 5'(got)) begin
          dups++;
          $display("FAIL bp_order got pc=%h rd=%0d exp pc=%h rd=%0d",
                   uop_out.pc, uop_out.rd,
                   exp_pc, got);
        end
        got++;
      end
      step();
      if (acc) sent++;
    end
    valid_in = 1'b0;
    checks++;
    if (got !== 5 || dups !== 0) begin
      errors++;
      $display("FAIL bp_stream got=%0d bad=%0d exp 5 in order",
               got, dups);
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_extra got v=%b pc=%h exp v=0",
               valid_out, uop_out.pc);
    end
  endtask

  task automatic fill_both(
    input logic [31:0] base
  );
    ready_out = 1'b0;
    drive(addi_enc(7), base);
    step();
    drive(addi_enc(8), base + 4);
    step();
    valid_in = 1'b0;
  endtask

  task automatic test_flush();
    int seen = 0;
    fill_both(32'h300);
    checks++;
    if (ready_in !== 1'b0 ||
        valid_out !== 1'b1) begin
      errors++;
      $display("FAIL fl_pre got rdy=%b v=%b exp rdy=0 v=1",
               ready_in, valid_out);
    end
    flush = 1'b1;
    drive(addi_enc(9), 32'h308);
    step();
    flush    = 1'b0;
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0 ||
        ready_in !== 1'b1) begin
      errors++;
      $display("FAIL fl_next got v=%b rdy=%b exp v=0 rdy=1",
               valid_out, ready_in);
    end
    ready_out = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (valid_out) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL fl_leak got=%0d exp=0",
               seen);
    end
  endtask

  task automatic test_mext();
    ready_out = 1'b1;
    drive(32'h022081B3, 32'h500);
    step();
`ifdef DECODE_RV32M_EN
    checks++;
    if (uop_out.fu_type !== FU_MDU ||
        uop_out.illegal !== 1'b0 ||
        uop_out.uses_rs2 !== 1'b1) begin
      errors++;
      $display("FAIL mul_en got fu=%0d ill=%b exp fu=4 ill=0",
               uop_out.fu_type,
               uop_out.illegal);
    end
`else
    checks++;
    if (uop_out.illegal !== 1'b1 ||
        uop_out.fu_type !== FU_NONE ||
        uop_out.uses_rd !== 1'b0) begin
      errors++;
      $display("FAIL mul_dis got ill=%b fu=%0d rdu=%b exp ill=1 fu=0 rdu=0",
               uop_out.illegal,
               uop_out.fu_type,
               uop_out.uses_rd);
    end
`endif
    drive(32'h00000000, 32'h504);
    step();
    checks++;
    if (uop_out.illegal !== 1'b1 ||
        valid_out !== 1'b1 ||
        uop_out.fu_type !== FU_NONE) begin
      errors++;
      $display("FAIL zero_ill got ill=%b v=%b fu=%0d exp ill=1 v=1 fu=0",
               uop_out.illegal, valid_out,
               uop_out.fu_type);
    end
    drive(32'h0000E003, 32'h508);
    step();
    valid_in = 1'b0;
    checks++;
    if (uop_out.illegal !== 1'b1 ||
        uop_out.is_load !== 1'b0) begin
      errors++;
      $display("FAIL ld_f3 got ill=%b ld=%b exp ill=1 ld=0",
               uop_out.illegal,
               uop_out.is_load);
    end
    step();
  endtask

  task automatic test_reset_mid();
    fill_both(32'h600);
    reset = 1'b0;
    step();
    checks++;
    if (valid_out !== 1'b0 ||
        uop_out !== '0 ||
        ready_in !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got v=%b rdy=%b uop=%h exp v=0 rdy=1 uop=0",
               valid_out, ready_in, uop_out);
    end
    reset     = 1'b1;
    ready_out = 1'b1;
    drive(32'hFFB10093, 32'h700);
    step();
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 ||
        uop_out.pc !== 32'h700 ||
        uop_out.imm !== 32'hFFFFFFFB) begin
      errors++;
      $display("FAIL rst_resume got v=%b pc=%h imm=%h exp v=1 pc=700 imm=fffffffb",
               valid_out, uop_out.pc,
               uop_out.imm);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_imm_formats();
    test_backpressure();
    test_flush();
    test_mext();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
